// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters and
// the counter-width helper used by the transmit (and later receive) side.
package uart_pkg;

  localparam int DBIT_DEF       = 8;
  localparam int OVS_DEF        = 16;
  localparam int SB_TICK_DEF    = 16;
  localparam int DVSR_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// FIFO read port between the transmit FIFO (slave) and its single reader, the
// UART transmitter (master).
interface uart_tx_fifo_if #(
  parameter int DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  modport master (input fifo_empty, input fifo_r_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_r_data, input fifo_rd);
endinterface

// File: rtl/baud_gen.sv
// Oversampling baud tick generator: one tick every dvsr+1 clk cycles.
module baud_gen #(
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  tick
);

  logic [DVSR_WIDTH-1:0] r_count;
  logic                  w_wrap;

  // A >= compare lets a lowered divisor take effect without overrunning.
  assign w_wrap = (r_count >= dvsr);
  assign tick   = w_wrap;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit stage: pops bytes from the TX FIFO and shifts them out as
// start + DBIT data bits (LSB first) + stop frames on a registered tx line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int OVS        = OVS_DEF,
  parameter int DVSR_WIDTH = DVSR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  tx_en,
  uart_tx_fifo_if.master        fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int S_W = cnt_width((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int N_W = cnt_width(DBIT);
  localparam logic [S_W-1:0] S_OVS_LAST = S_W'(OVS - 1);
  localparam logic [S_W-1:0] S_SB_LAST  = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);

  state_t          r_state, w_state_next;
  logic [S_W-1:0]  r_s, w_s_next;
  logic [N_W-1:0]  r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next;
  logic            r_tx, w_tx_next;
  logic            w_tick, w_rd, w_done;

  baud_gen #(.DVSR_WIDTH(DVSR_WIDTH)) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .dvsr (dvsr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_tx    <= w_tx_next;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_tx_next    = 1'b1;
    w_rd         = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Gating with reset keeps the FIFO from being popped while held in reset.
        if (tx_en && !fifo.fifo_empty && !reset) begin
          w_rd         = 1'b1;
          w_b_next     = fifo.fifo_r_data;
          w_s_next     = '0;
          w_state_next = START;
        end
      end
      START: begin
        w_tx_next = 1'b0;
        if (w_tick) begin
          if (r_s == S_OVS_LAST) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = DATA;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        w_tx_next = r_b[0];
        if (w_tick) begin
          if (r_s == S_OVS_LAST) begin
            w_s_next = '0;
            w_b_next = r_b >> 1;
            if (r_n == N_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == S_SB_LAST) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = w_done;
  assign fifo.fifo_rd = w_rd;

endmodule
